// File: rtl/free_list_arbiter_pkg.sv
// Shared types and width helpers for the free-list allocator.
package free_list_arbiter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fl_state_e;

  // Bits needed to hold values 0..n-1 (minimum 1).
  function automatic int unsigned bits_for(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/free_list_arbiter_if.sv
// Bundle of the allocate/free handshake signals around free_list_arbiter.
interface free_list_arbiter_if
  import free_list_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned INIT_VAL  = 0
);
  localparam int unsigned AW = bits_for(INIT_VAL + DEPTH);
  localparam int unsigned CW = bits_for(DEPTH + 1);

  logic [NUM_PORTS-1:0] alloc_req;
  logic [NUM_PORTS-1:0] alloc_gnt;
  logic [AW-1:0]        alloc_addr;
  logic                 free_valid;
  logic [AW-1:0]        free_addr;
  logic                 free_ready;
  logic [CW-1:0]        free_count;
  logic                 init_done;

  modport master (
    output alloc_req, free_valid, free_addr,
    input  alloc_gnt, alloc_addr, free_ready, free_count, init_done
  );

  modport slave (
    input  alloc_req, free_valid, free_addr,
    output alloc_gnt, alloc_addr, free_ready, free_count, init_done
  );

endinterface

// File: rtl/free_list_arbiter_rr.sv
// Round-robin arbiter: one-hot grant, search starts after the last winner.
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 gnt_en,
  output logic [NUM_PORTS-1:0] gnt
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] sel;
  logic          found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sel   = '0;
    if (gnt_en) begin
      for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
        sel = PW'((32'(ptr_q) + off) % NUM_PORTS);
        if (!found && req[sel]) begin
          found    = 1'b1;
          gnt[sel] = 1'b1;
          ptr_d    = sel;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PW'(NUM_PORTS - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/free_list_arbiter.sv
// Circular free list of addresses, loaded at reset, handed out to
// round-robin-arbitrated requesters and refilled by returns.
module free_list_arbiter
  import free_list_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 4,
  parameter  int unsigned DEPTH     = 16,
  parameter  int unsigned INIT_VAL  = 0,
  // Address width covers INIT_VAL+DEPTH-1; equals $clog2(DEPTH) when INIT_VAL is 0.
  localparam int unsigned AW        = bits_for(INIT_VAL + DEPTH),
  localparam int unsigned CW        = bits_for(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] i__alloc_req,
  output logic [NUM_PORTS-1:0] o__alloc_gnt,
  output logic [AW-1:0]        o__alloc_addr,
  input  logic                 i__free_valid,
  input  logic [AW-1:0]        i__free_addr,
  output logic                 o__free_ready,
  output logic [CW-1:0]        o__free_count,
  output logic                 o__init_done
);

  localparam int unsigned PW = bits_for(DEPTH);

  fl_state_e     state_q, state_d;
  logic [PW-1:0] init_cnt_q, init_cnt_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          init_done_q, init_done_d;

  logic [AW-1:0] mem_q [DEPTH];
  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic [AW-1:0] wr_data;

  logic          gnt_en;
  logic          pop;
  logic          push;

  function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign gnt_en = (state_q == ST_RUN) && (count_q != '0);

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .clk    (clk),
    .rst_n  (reset),
    .req    (i__alloc_req),
    .gnt_en (gnt_en),
    .gnt    (o__alloc_gnt)
  );

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    init_done_d   = init_done_q;
    wr_en         = 1'b0;
    wr_idx        = tail_q;
    wr_data       = i__free_addr;
    o__free_ready = 1'b0;
    pop           = 1'b0;
    push          = 1'b0;
    case (state_q)
      ST_INIT: begin
        wr_en   = 1'b1;
        wr_idx  = init_cnt_q;
        wr_data = AW'(INIT_VAL + 32'(init_cnt_q));
        if (init_cnt_q == PW'(DEPTH - 1)) begin
          state_d = ST_RUN;
          count_d = CW'(DEPTH);
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        init_done_d   = 1'b1;
        o__free_ready = (count_q < CW'(DEPTH));
        pop           = |o__alloc_gnt;
        push          = i__free_valid && o__free_ready;
        if (push) begin
          wr_en  = 1'b1;
          tail_d = next_slot(tail_q);
        end
        if (pop) head_d = next_slot(head_q);
        count_d = count_q + CW'(push) - CW'(pop);
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign o__alloc_addr = mem_q[head_q];
  assign o__free_count = count_q;
  assign o__init_done  = init_done_q;

endmodule

// File: tb/tb_free_list_arbiter.sv
// Scoreboard bench: queue-based free-list model predicts every cycle's outputs.
module tb_free_list_arbiter;
  import free_list_arbiter_pkg::*;

  localparam int unsigned NP       = 3;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned INIT_VAL = 8;
  localparam int unsigned AW       = bits_for(INIT_VAL + DEPTH);
  localparam int unsigned CW       = bits_for(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  free_list_arbiter_if #(.NUM_PORTS(NP), .DEPTH(DEPTH), .INIT_VAL(INIT_VAL)) bus ();

  free_list_arbiter #(.NUM_PORTS(NP), .DEPTH(DEPTH), .INIT_VAL(INIT_VAL)) dut (
    .clk           (clk),
    .reset         (reset),
    .i__alloc_req  (bus.alloc_req),
    .o__alloc_gnt  (bus.alloc_gnt),
    .o__alloc_addr (bus.alloc_addr),
    .i__free_valid (bus.free_valid),
    .i__free_addr  (bus.free_addr),
    .o__free_ready (bus.free_ready),
    .o__free_count (bus.free_count),
    .o__init_done  (bus.init_done)
  );

  typedef struct {
    logic [NP-1:0] gnt;
    logic [AW-1:0] addr;
    logic [CW-1:0] count;
    logic          ready;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: the list of free addresses in hand-out order.
  int            edges;
  int            last;
  logic [AW-1:0] fl[$];
  logic [AW-1:0] out_list[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [NP-1:0] req, input logic fv, input logic [AW-1:0] fa,
                      output logic [NP-1:0] g);
    exp_t e;
    bit   run;
    bit   found;
    int   p;
    @(posedge clk);
    edges++;
    if (edges == DEPTH)
      for (int k = 0; k < DEPTH; k++) fl.push_back(AW'(INIT_VAL + k));
    #1;
    bus.alloc_req  = req;
    bus.free_valid = fv;
    bus.free_addr  = fa;
    run     = (edges >= DEPTH);
    e.gnt   = '0;
    e.addr  = '0;
    e.count = CW'(fl.size());
    e.ready = run && (fl.size() < DEPTH);
    e.done  = (edges > DEPTH);
    found   = 0;
    if (run && fl.size() > 0) begin
      for (int off = 1; off <= NP; off++) begin
        p = (last + off) % NP;
        if (!found && req[p]) begin
          found    = 1;
          e.gnt[p] = 1'b1;
          e.addr   = fl[0];
          last     = p;
        end
      end
    end
    exp_q.push_back(e);
    if (found) out_list.push_back(fl.pop_front());
    if (fv && e.ready) begin
      fl.push_back(fa);
      found = 0;
      for (int i = 0; i < out_list.size(); i++)
        if (!found && out_list[i] == fa) begin
          out_list.delete(i);
          found = 1;
        end
    end
    g = e.gnt;
  endtask

  task automatic model_reset();
    edges = 0;
    last  = NP - 1;
    fl.delete();
    out_list.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_gnt",   32'(bus.alloc_gnt),  32'd0);
    check("rst_ready", 32'(bus.free_ready), 32'd0);
    check("rst_done",  32'(bus.init_done),  32'd0);
    check("rst_count", 32'(bus.free_count), 32'd0);
    bus.alloc_req  = '0;
    bus.free_valid = 1'b0;
    bus.free_addr  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt", 32'(bus.alloc_gnt), 32'(e.gnt));
        if (e.gnt != '0) check("addr", 32'(bus.alloc_addr), 32'(e.addr));
        check("count", 32'(bus.free_count), 32'(e.count));
        check("ready", 32'(bus.free_ready), 32'(e.ready));
        check("done",  32'(bus.init_done),  32'(e.done));
      end else if (bus.alloc_gnt !== '0) begin
        check("idle_gnt", 32'(bus.alloc_gnt), 32'd0);
      end
    end
  end

  initial begin
    logic [NP-1:0] g;
    logic [NP-1:0] pending;
    logic          fv;
    logic [AW-1:0] fa;

    reset          = 1'b0;
    bus.alloc_req  = '0;
    bus.free_valid = 1'b0;
    bus.free_addr  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;

    // Initial load with no traffic, then four grants draining the list.
    repeat (5) step('0, 1'b0, '0, g);
    repeat (5) step(3'b111, 1'b0, '0, g);

    // Return while empty: no bypass, granted the following cycle.
    step(3'b010, 1'b1, AW'(9), g);
    step(3'b010, 1'b0, '0, g);

    // Refill to full, then a return while full is refused.
    step('0, 1'b1, AW'(10), g);
    step('0, 1'b1, AW'(11), g);
    step('0, 1'b1, AW'(8), g);
    step('0, 1'b1, AW'(9), g);
    step('0, 1'b1, AW'(2), g);
    step('0, 1'b0, '0, g);

    // Simultaneous grant and return at count 2; 10 comes out last.
    step(3'b001, 1'b0, '0, g);
    step(3'b001, 1'b0, '0, g);
    step(3'b100, 1'b1, AW'(10), g);
    step(3'b010, 1'b0, '0, g);
    step(3'b001, 1'b0, '0, g);
    step('0, 1'b0, '0, g);

    // Reset during the second init cycle, then a full reload.
    pulse_reset();
    step('0, 1'b0, '0, g);
    step('0, 1'b0, '0, g);
    pulse_reset();
    repeat (3) step(3'b111, 1'b1, AW'(5), g);
    repeat (5) step(3'b111, 1'b0, '0, g);

    // Random traffic with a mid-run reset.
    pending = '0;
    for (int unsigned it = 0; it < 400; it++) begin
      if (it == 200) begin
        pulse_reset();
        pending = '0;
      end
      if ($urandom_range(0, 2) == 0) pending |= NP'($urandom_range(1, (1 << NP) - 1));
      fv = 1'b0;
      fa = '0;
      if (out_list.size() > 0 && $urandom_range(0, 1) == 1) begin
        fv = 1'b1;
        fa = out_list[$urandom_range(0, out_list.size() - 1)];
      end else if (fl.size() == DEPTH && $urandom_range(0, 3) == 0) begin
        fv = 1'b1;
        fa = AW'($urandom);
      end
      step(pending, fv, fa, g);
      pending &= ~g;
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/free_list_arbiter.md
FREE_LIST_ARBITER -- requirements
Module: free_list_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of allocation requesters.
REQ-002 SHALL have parameter DEPTH, default 16, number of managed addresses.
REQ-003 SHALL have parameter INIT_VAL, default 0, value of the first managed address.
REQ-004 SHALL have port clk  in  1  sole clock, all state on posedge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i__alloc_req  in  NUM_PORTS  per-port allocation request, level, held until granted.
REQ-007 SHALL have port o__alloc_gnt  out  NUM_PORTS  one-hot grant, at most one bit set.
REQ-008 SHALL have port o__alloc_addr  out  $clog2(DEPTH)  address handed to the granted port.
REQ-009 SHALL have port i__free_valid  in  1  returned-address valid.
REQ-010 SHALL have port i__free_addr  in  $clog2(DEPTH)  address being returned.
REQ-011 SHALL have port o__free_ready  out  1  free-list can accept a return.
REQ-012 SHALL have port o__free_count  out  $clog2(DEPTH+1)  addresses currently available.
REQ-013 SHALL have port o__init_done  out  1  high once the initial load completes.

Function
REQ-014 SHALL implement states INIT and RUN; reset enters INIT.
REQ-015 In INIT, SHALL write INIT_VAL+k into free-list slot k on cycle k, for k = 0..DEPTH-1, one per cycle.
REQ-016 SHALL transition INIT->RUN on the cycle slot DEPTH-1 is written; o__init_done rises the following cycle and stays high until reset.
REQ-017 In INIT, SHALL hold o__alloc_gnt=0, o__free_ready=0 and ignore i__alloc_req and i__free_valid.
REQ-018 In RUN with o__free_count>0 and any i__alloc_req bit set, SHALL assert exactly one o__alloc_gnt bit combinationally in the same cycle, with o__alloc_addr = free-list head.
REQ-019 Grant selection SHALL be round-robin: search starts at the port after the last granted port and wraps NUM_PORTS-1->0; the pointer updates only on a grant cycle.
REQ-020 With o__free_count=0, SHALL hold o__alloc_gnt=0; requests stay pending.
REQ-021 A grant SHALL pop the head at the clock edge; the requester treats req&gnt as the transfer.
REQ-022 o__free_ready SHALL be high in RUN iff o__free_count<DEPTH; a return is accepted when i__free_valid&o__free_ready and pushed at the tail.
REQ-023 A grant and an accepted return in the same cycle SHALL both take effect, with o__free_count unchanged; a returned address SHALL NOT be bypassed to a same-cycle grant.
REQ-024 o__free_count SHALL equal DEPTH after INIT and change by +1 per return, -1 per grant, never wrapping.
REQ-025 Head and tail pointers SHALL wrap DEPTH-1->0, including non-power-of-two DEPTH.
REQ-026 Returned addresses SHALL come back out in FIFO order after all earlier entries.

Reset
REQ-027 Reset assertion SHALL asynchronously force INIT, init counter 0, head 0, tail 0, count 0, round-robin pointer NUM_PORTS-1, o__init_done=0, o__alloc_gnt=0, o__free_ready=0.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL discard all outstanding state; a full INIT reload follows deassertion.
REQ-029 Storage array contents need no reset; INIT overwrites every slot.

Structure
REQ-030 SHALL place the INIT/RUN state enum in the shared project package.
REQ-031 SHALL instantiate a sub-module rr_arbiter (parameter NUM_PORTS; inputs req and grant-enable; output one-hot grant) that owns the round-robin pointer.
REQ-032 Free-list storage and pointers SHALL be local to free_list_arbiter.

Verification (NUM_PORTS=3, DEPTH=4, INIT_VAL=8)
REQ-033 Reset release, no requests -> o__init_done high on cycle 5; o__free_count=4; o__free_ready=0.
REQ-034 After init, req=3'b111 held for 4 cycles -> grants 001,010,100,001 with addrs 8,9,10,11; then count=0, gnt=0.
REQ-035 Count=0, return addr 9 with req=3'b010 in the same cycle -> gnt=0 that cycle; next cycle gnt=010, addr=9.
REQ-036 Count=4, free_valid=1 -> free_ready=0, count stays 4.
REQ-037 Count=2, grant plus return of addr 10 in the same cycle -> count stays 2; 10 emerges after the two older entries.
REQ-038 Reset asserted during INIT cycle 2 -> outputs zero immediately; after release, addrs 8..11 are reloaded and count=4.
